// File: rtl/command_decoder_pkg.sv
// command_decoder_pkg
//   Shared definitions for the UART command decoder: command byte values
//   recognised in IDLE and the decoder state encoding.
package command_decoder_pkg;

   localparam logic [7:0] CMD_LOAD     = 8'h4C;  // 'L' : load one row of frame data
   localparam logic [7:0] CMD_RGB      = 8'h52;  // 'R' : set colour channel mask
   localparam logic [7:0] CMD_BRIGHT   = 8'h62;  // 'b' : set brightness bit-plane mask
   localparam logic [7:0] CMD_DEFAULTS = 8'h72;  // 'r' : restore both masks to all-ones

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ROW    = 3'd1,
      ST_DATA   = 3'd2,
      ST_RGB    = 3'd3,
      ST_BRIGHT = 3'd4
   } cmd_state_e;

endpackage

// File: rtl/command_decoder_timeout.sv
// cmd_timeout
//   Idle-gap watchdog for a command in progress.
//   Ports:
//     clk_in  - clock, rising edge
//     reset   - asynchronous active-low reset
//     clear   - restart the count from zero (has priority over enable)
//     enable  - count this cycle (a command is in progress)
//     expired - count has reached TIMEOUT_CYCLES while enabled
//   The count saturates at TIMEOUT_CYCLES so expired stays asserted until
//   the owner clears it.
module cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk_in,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LIMIT)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/command_decoder.sv
// command_decoder
//   Decodes a byte stream from a UART receiver into frame-RAM writes and
//   display mask settings.
//   Commands (first byte, in IDLE):
//     'L' row d0..d(N-1) : write N bytes to row*BYTES_PER_ROW + k
//     'R' m              : rgb_enable <= m[NUM_CHANNELS-1:0]
//     'b' m              : brightness_enable <= m[BRIGHTNESS_W-1:0]
//     'r'                : both masks back to all-ones
//   Ports:
//     clk_in, reset         - clock / asynchronous active-low reset
//     rx_data, rx_valid     - received byte and its one-cycle strobe
//     ram_data_out, ram_address, ram_write_enable - registered RAM write port
//     rgb_enable, brightness_enable               - registered masks
//     busy                  - a command is in progress
//     frame_done, cmd_error - single-cycle status pulses
//     dbg_state             - current decoder state
//   Handshake: rx_valid is a strobe with no back-pressure; every byte
//   presented with rx_valid high is consumed in that cycle, and its effect
//   appears on the registered outputs one cycle later.
module command_decoder
   import command_decoder_pkg::*;
#(
   parameter int NUM_CHANNELS   = 3,
   parameter int BRIGHTNESS_W   = 6,
   parameter int ROWS           = 16,
   parameter int BYTES_PER_ROW  = 64,
   parameter int ADDR_W         = $clog2(ROWS * BYTES_PER_ROW),
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic [7:0]              ram_data_out,
   output logic [ADDR_W-1:0]       ram_address,
   output logic                    ram_write_enable,
   output logic [NUM_CHANNELS-1:0] rgb_enable,
   output logic [BRIGHTNESS_W-1:0] brightness_enable,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    cmd_error,
   output cmd_state_e              dbg_state
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_ROW - 1);

   if (ROWS * BYTES_PER_ROW > (1 << ADDR_W)) begin : g_addr_check
      $error("command_decoder: ROWS*BYTES_PER_ROW does not fit in ADDR_W bits");
   end
   if (NUM_CHANNELS > 8 || BRIGHTNESS_W > 8) begin : g_mask_check
      $error("command_decoder: mask widths must not exceed 8 bits");
   end

   cmd_state_e              state_q, state_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic [CNT_W-1:0]        byte_cnt_q, byte_cnt_d;
   logic [7:0]              ram_data_q, ram_data_d;
   logic [ADDR_W-1:0]       ram_addr_q, ram_addr_d;
   logic                    we_q, we_d;
   logic                    frame_done_q, frame_done_d;
   logic                    cmd_error_q, cmd_error_d;
   logic [NUM_CHANNELS-1:0] rgb_q, rgb_d;
   logic [BRIGHTNESS_W-1:0] bright_q, bright_d;

   logic timeout_expired;

   // Counter runs only while a command is open and restarts on every byte;
   // entering a non-IDLE state always happens on a byte, so that restart
   // also covers the state entry.
   cmd_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_in  (clk_in),
      .reset   (reset),
      .clear   (rx_valid || (state_q == ST_IDLE)),
      .enable  (state_q != ST_IDLE),
      .expired (timeout_expired)
   );

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      byte_cnt_d   = byte_cnt_q;
      ram_data_d   = ram_data_q;
      ram_addr_d   = ram_addr_q;
      we_d         = 1'b0;
      frame_done_d = 1'b0;
      cmd_error_d  = 1'b0;
      rgb_d        = rgb_q;
      bright_d     = bright_q;

      // A byte arriving in the expiry cycle wins over the timeout.
      if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               case (rx_data)
                  CMD_LOAD:     state_d = ST_ROW;
                  CMD_RGB:      state_d = ST_RGB;
                  CMD_BRIGHT:   state_d = ST_BRIGHT;
                  CMD_DEFAULTS: begin
                     rgb_d    = '1;
                     bright_d = '1;
                  end
                  default:      cmd_error_d = 1'b1;
               endcase
            end
            ST_ROW: begin
               if (int'({24'd0, rx_data}) < ROWS) begin
                  row_d      = ROW_W'(rx_data);
                  byte_cnt_d = '0;
                  state_d    = ST_DATA;
               end else begin
                  cmd_error_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
            ST_DATA: begin
               // Every byte here is payload, command values included.
               ram_data_d = rx_data;
               ram_addr_d = ADDR_W'(row_q) * ADDR_W'(BYTES_PER_ROW) + ADDR_W'(byte_cnt_q);
               we_d       = 1'b1;
               byte_cnt_d = byte_cnt_q + 1'b1;
               if (byte_cnt_q == LAST_BYTE) begin
                  frame_done_d = 1'b1;
                  state_d      = ST_IDLE;
               end
            end
            ST_RGB: begin
               rgb_d   = rx_data[NUM_CHANNELS-1:0];
               state_d = ST_IDLE;
            end
            ST_BRIGHT: begin
               bright_d = rx_data[BRIGHTNESS_W-1:0];
               state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (timeout_expired) begin
         cmd_error_d = 1'b1;
         state_d     = ST_IDLE;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         byte_cnt_q   <= '0;
         ram_data_q   <= '0;
         ram_addr_q   <= '0;
         we_q         <= 1'b0;
         frame_done_q <= 1'b0;
         cmd_error_q  <= 1'b0;
         rgb_q        <= '1;
         bright_q     <= '1;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         byte_cnt_q   <= byte_cnt_d;
         ram_data_q   <= ram_data_d;
         ram_addr_q   <= ram_addr_d;
         we_q         <= we_d;
         frame_done_q <= frame_done_d;
         cmd_error_q  <= cmd_error_d;
         rgb_q        <= rgb_d;
         bright_q     <= bright_d;
      end
   end

   assign ram_data_out      = ram_data_q;
   assign ram_address       = ram_addr_q;
   assign ram_write_enable  = we_q;
   assign frame_done        = frame_done_q;
   assign cmd_error         = cmd_error_q;
   assign rgb_enable        = rgb_q;
   assign brightness_enable = bright_q;
   assign busy              = (state_q != ST_IDLE);
   assign dbg_state         = state_q;

endmodule

// File: doc/command_decoder.md
COMMAND_DECODER -- requirements
Module: command_decoder

Interface
REQ-001 Parameter NUM_CHANNELS, default 3, width of rgb_enable (one bit per colour channel).
REQ-002 Parameter BRIGHTNESS_W, default 6, width of brightness_enable.
REQ-003 Parameter ROWS, default 16, number of addressable display rows.
REQ-004 Parameter BYTES_PER_ROW, default 64, data bytes loaded per 'L' command.
REQ-005 Parameter ADDR_W, default $clog2(ROWS*BYTES_PER_ROW), RAM address width.
REQ-006 Parameter TIMEOUT_CYCLES, default 4096, maximum idle clk_in cycles between bytes of one command.
REQ-007 clk_in  in  1  single clock; all logic rising-edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 rx_data  in  8  received UART byte.
REQ-010 rx_valid  in  1  one-cycle strobe; rx_data valid this cycle.
REQ-011 ram_data_out  out  8  byte to write into frame RAM.
REQ-012 ram_address  out  ADDR_W  write address.
REQ-013 ram_write_enable  out  1  one-cycle RAM write strobe.
REQ-014 rgb_enable  out  NUM_CHANNELS  channel enable mask.
REQ-015 brightness_enable  out  BRIGHTNESS_W  brightness bit-plane mask.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 frame_done  out  1  one-cycle pulse after last data byte of an 'L' command is written.
REQ-018 cmd_error  out  1  one-cycle pulse on any protocol error.

Function
REQ-019 States SHALL be IDLE, ROW, DATA, RGB, BRIGHT; only rx_valid cycles advance the state, except timeout.
REQ-020 In IDLE: 'L'(0x4C)->ROW; 'R'(0x52)->RGB; 'b'(0x62)->BRIGHT; 'r'(0x72) sets rgb_enable and brightness_enable to all-ones, stays IDLE; any other byte pulses cmd_error, stays IDLE.
REQ-021 ROW: byte < ROWS latches row index, clears byte counter, ->DATA; byte >= ROWS pulses cmd_error, ->IDLE.
REQ-022 DATA: each byte k (0..BYTES_PER_ROW-1) SHALL drive ram_data_out=byte, ram_address=row*BYTES_PER_ROW+k, ram_write_enable=1 on the cycle after rx_valid (latency 1).
REQ-023 DATA: after byte k=BYTES_PER_ROW-1, frame_done SHALL pulse in the same cycle as that write strobe and state ->IDLE.
REQ-024 RGB: rgb_enable <= rx_data[NUM_CHANNELS-1:0], ->IDLE; BRIGHT: brightness_enable <= rx_data[BRIGHTNESS_W-1:0], ->IDLE (NUM_CHANNELS, BRIGHTNESS_W <= 8).
REQ-025 Timeout counter SHALL clear on entering a non-IDLE state and on every rx_valid; if it reaches TIMEOUT_CYCLES outside IDLE, cmd_error pulses, state ->IDLE, no further writes.
REQ-026 rx_valid in the same cycle as timeout expiry: byte SHALL be processed, timeout suppressed.
REQ-027 Bytes received in DATA are always data, including 0x4C etc. (no escape).
REQ-028 ram_write_enable, frame_done, cmd_error SHALL be single-cycle; ram_address/ram_data_out hold last value otherwise.
REQ-029 Address arithmetic SHALL be performed at ADDR_W bits; ROWS*BYTES_PER_ROW <= 2**ADDR_W checked at elaboration.

Reset
REQ-030 On reset low: state IDLE, ram_write_enable=0, ram_address=0, ram_data_out=0, rgb_enable=all-ones, brightness_enable=all-ones, busy=0, frame_done=0, cmd_error=0, counters=0.
REQ-031 Reset asserted mid-command SHALL abort immediately; a partial row remains partially written; no frame_done.

Structure
REQ-032 Shared package SHALL hold command byte constants (CMD_LOAD, CMD_RGB, CMD_BRIGHT, CMD_DEFAULTS) and the state enum.
REQ-033 One sub-module cmd_timeout (clear, enable, expired; parameter TIMEOUT_CYCLES) SHALL implement REQ-025.

Verification
REQ-034 'L',0x02, then 64 bytes 0x00..0x3F -> 64 writes, addresses 128..191, data 0x00..0x3F, frame_done once with address 191.
REQ-035 'R',0x05 -> rgb_enable=3'b101; 'b',0x2A -> brightness_enable=6'b101010; 'r' -> both all-ones.
REQ-036 'L',0x10 (ROWS=16) -> cmd_error pulse, no writes, busy=0; 'x' in IDLE -> cmd_error pulse.
REQ-037 'L',0x00, 10 bytes, then silence TIMEOUT_CYCLES -> cmd_error, IDLE, exactly 10 writes; next 'R',0x01 accepted normally.
REQ-038 rx_valid coincident with timeout expiry -> byte written, no cmd_error.
REQ-039 Reset low after 5 data bytes -> outputs at reset values, subsequent full 'L' command completes with frame_done.
